param_shift_reg: RTL and testbench
==================================

PARAM_SHIFT_REG -- requirements
Module: param_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port en  input  1  clock enable; when low, all state holds.
REQ-005 The block SHALL have port mode  input  3  operation select, decoded per REQ-010.
REQ-006 The block SHALL have port sin_l  input  1  serial-in for shift-left, entering at bit 0.
REQ-007 The block SHALL have port sin_r  input  1  serial-in for shift-right, entering at bit WIDTH-1.
REQ-008 The block SHALL have port d  input  WIDTH  parallel-load data.
REQ-009 The block SHALL have the following outputs:
- q  output  WIDTH  register contents.
- sout_l  output  1  equals q[WIDTH-1], combinational from q.
- sout_r  output  1  equals q[0], combinational from q.
- shift_cnt  output  clog2(WIDTH)  number of shifts since last load/reset, modulo WIDTH.
- word_done  output  1  one-cycle pulse, registered, per REQ-014.

Function
REQ-010 On a rising clk edge with en=1, q SHALL update by mode:
- 000 hold.
- 001 shift left: q <= {q[W-2:0], sin_l}.
- 010 shift right: q <= {sin_r, q[W-1:1]}.
- 011 rotate left: q <= {q[W-2:0], q[W-1]}.
- 100 rotate right: q <= {q[0], q[W-1:1]}.
- 101 parallel load: q <= d.
- 110 arithmetic shift right (see REQ-020).
- 111 hold.
REQ-011 Modes 001-100 are "shift operations" and SHALL increment shift_cnt by 1 on the same edge; the count wraps from WIDTH-1 to 0.
REQ-012 Parallel load (101) SHALL clear shift_cnt to 0 on the same edge; hold modes leave shift_cnt unchanged.
REQ-013 With en=0, q, shift_cnt and the counter state SHALL hold regardless of mode; word_done SHALL be 0 in the following cycle.
REQ-014 word_done SHALL be 1 for exactly the one cycle following the edge on which shift_cnt wraps from WIDTH-1 to 0; it is 0 at all other times.
REQ-015 Mixed directions SHALL count equally: any WIDTH shift operations, in any mix of modes 001-100 with no intervening load, SHALL produce one word_done.
REQ-016 Operation latency SHALL be one edge: q reflects the operation in the cycle after the enabling edge, and sout_l/sout_r follow q in the same cycle.

Reset
REQ-017 When rst=1 at a rising edge, the block SHALL set q=0, shift_cnt=0 and word_done=0, regardless of en and mode.
REQ-018 rst SHALL take priority over all modes.
REQ-019 A reset asserted mid-word SHALL discard the partial shift count, so that no word_done is produced for the shifts that preceded it.

Configuration
REQ-020 Macro PARAM_SHIFT_REG_ARITH_EN SHALL control mode 110:
- Defined: mode 110 is an arithmetic shift right, q <= {q[W-1], q[W-1:1]}, and counts as a shift operation.
- Undefined: mode 110 behaves as hold and does not change shift_cnt.

Verification
REQ-021 The bench SHALL cover the following directed scenarios (WIDTH=4):
- Reset, then load d=4'b1011 -> q=1011, shift_cnt=0 next cycle.
- From q=1011, four mode-001 shifts with sin_l=0 -> q sequence 0110, 1100, 1000, 0000; word_done=1 only in the cycle after the 4th shift.
- From q=1011, mode 100 once -> q=1101; mode 011 once -> q=1011; shift_cnt=2; no word_done.
- From q=1000, mode 110: with ARITH_EN defined -> q=1100, shift_cnt+1; without it -> q=1000, shift_cnt unchanged.
- en=0 while mode=001 for 3 cycles -> q and shift_cnt unchanged, word_done=0.
- Two shifts, then rst=1 with mode=101, d=1111 -> q=0000, shift_cnt=0; four later shifts -> exactly one word_done.

Source files
------------

// File: rtl/param_shift_reg.sv
// Parameterised shift register: shift/rotate/load with a modulo-WIDTH shift counter and word-done pulse.
// Latency: one clock edge from an enabled operation to q, shift_cnt and word_done.
// No backpressure: en is a plain clock enable, and all state holds while it is low.
// Optional feature: define PARAM_SHIFT_REG_ARITH_EN to make mode 110 an arithmetic shift right.
module param_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2:0]               mode,
    input  logic                     sin_l,
    input  logic                     sin_r,
    input  logic [WIDTH-1:0]         d,
    output logic [WIDTH-1:0]         q,
    output logic                     sout_l,
    output logic                     sout_r,
    output logic [$clog2(WIDTH)-1:0] shift_cnt,
    output logic                     word_done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_ROL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LOAD = 3'b101;
`ifdef PARAM_SHIFT_REG_ARITH_EN
    localparam logic [2:0] MODE_ASR  = 3'b110;
`endif

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_word_done;
    logic [WIDTH-1:0] w_q_nxt;
    logic             w_is_shift;

    // Decode the operation into the next register value and whether it counts as a shift.
    always_comb begin
        w_q_nxt    = r_q;
        w_is_shift = 1'b0;
        case (mode)
            MODE_SHL: begin
                w_q_nxt    = {r_q[WIDTH-2:0], sin_l};
                w_is_shift = 1'b1;
            end
            MODE_SHR: begin
                w_q_nxt    = {sin_r, r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            MODE_ROL: begin
                w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_is_shift = 1'b1;
            end
            MODE_ROR: begin
                w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            MODE_LOAD: begin
                w_q_nxt    = d;
            end
`ifdef PARAM_SHIFT_REG_ARITH_EN
            MODE_ASR: begin
                w_q_nxt    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
`endif
            default: begin
                // Modes 000 and 111 (and 110 without the arithmetic option) hold.
                w_q_nxt    = r_q;
            end
        endcase
    end

    // Register update. The counter wraps explicitly at WIDTH-1 so that non-power-of-two widths
    // still produce one word_done per WIDTH shifts. Reset discards any partial count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            r_cnt       <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (en) begin
                r_q <= w_q_nxt;
                if (mode == MODE_LOAD) begin
                    r_cnt <= '0;
                end else if (w_is_shift) begin
                    if (r_cnt == CNT_MAX) begin
                        r_cnt       <= '0;
                        r_word_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign q         = r_q;
    assign sout_l    = r_q[WIDTH-1];
    assign sout_r    = r_q[0];
    assign shift_cnt = r_cnt;
    assign word_done = r_word_done;

endmodule

// File: tb/tb_param_shift_reg.sv
// Scoreboard bench for param_shift_reg at WIDTH=4: a driver pushes model predictions tagged with
// the cycle they apply to, and a monitor pops and compares them against the DUT outputs.
// The reference model works on integers (multiply/divide/modulo), not on bit slices.
module tb_param_shift_reg;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic         sin_l = 1'b0;
    logic         sin_r = 1'b0;
    logic [W-1:0] d = '0;
    logic [W-1:0] q;
    logic         sout_l;
    logic         sout_r;
    logic [1:0]   shift_cnt;
    logic         word_done;

    param_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .d         (d),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .shift_cnt (shift_cnt),
        .word_done (word_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tag;
        int q;
        int cnt;
        int wd;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    // Reference model state: register value, shifts since last load/reset, pending pulse.
    int m_q = 0;
    int m_sh = 0;
    int m_wd = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare every prediction due in the cycle that just closed.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].tag <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("q",         int'(q),         e.q);
            chk("shift_cnt", int'(shift_cnt), e.cnt);
            chk("word_done", int'(word_done), e.wd);
            chk("sout_l",    int'(sout_l),    e.q / 8);
            chk("sout_r",    int'(sout_r),    e.q % 2);
        end
    end

    // Apply one cycle of stimulus and push the predicted post-edge state.
    task automatic step(input bit r, input bit e, input int md, input bit sl, input bit sr, input int dv);
        bit   is_shift;
        exp_t x;
        @(posedge clk);
        #1;
        rst   = r;
        en    = e;
        mode  = 3'(md);
        sin_l = sl;
        sin_r = sr;
        d     = W'(dv);
        is_shift = 1'b0;
        if (r) begin
            m_q = 0; m_sh = 0; m_wd = 0;
        end else begin
            m_wd = 0;
            if (e) begin
                case (md)
                    1: begin m_q = (m_q * 2) % 16 + int'(sl);        is_shift = 1'b1; end
                    2: begin m_q = m_q / 2 + 8 * int'(sr);            is_shift = 1'b1; end
                    3: begin m_q = (m_q * 2) % 16 + m_q / 8;          is_shift = 1'b1; end
                    4: begin m_q = m_q / 2 + 8 * (m_q % 2);           is_shift = 1'b1; end
                    5: begin m_q = dv; m_sh = 0; end
`ifdef PARAM_SHIFT_REG_ARITH_EN
                    6: begin m_q = m_q / 2 + ((m_q >= 8) ? 8 : 0); is_shift = 1'b1; end
`endif
                    default: ;
                endcase
                if (is_shift) begin
                    m_sh = m_sh + 1;
                    if (m_sh % W == 0) m_wd = 1;
                end
            end
        end
        x.tag = cyc + 1;
        x.q   = m_q;
        x.cnt = m_sh % W;
        x.wd  = m_wd;
        sb.push_back(x);
    endtask

    initial begin
        // Reset, then load 1011.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 15);
        step(0, 1, 5, 0, 0, 4'b1011);
        // Four shift-lefts with sin_l=0; pulse follows only the fourth.
        repeat (4) step(0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 7, 0, 0, 0);
        // Rotate right then rotate left from 1011.
        step(0, 1, 5, 0, 0, 4'b1011);
        step(0, 1, 4, 0, 0, 0);
        step(0, 1, 3, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // Mode 110 from 1000.
        step(0, 1, 5, 0, 0, 4'b1000);
        step(0, 1, 6, 0, 0, 0);
        // Clock enable low with a shift mode selected.
        repeat (3) step(0, 0, 1, 1, 1, 0);
        // Two shifts, reset with a load request, then a full word of mixed shifts.
        step(0, 1, 5, 0, 0, 4'b0101);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 2, 0, 1, 0);
        step(1, 1, 5, 0, 0, 4'b1111);
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 2, 0, 1, 0);
        step(0, 1, 3, 0, 0, 0);
        step(0, 1, 4, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // Enable low on the wrap edge must not pulse; next enabled shift does.
        step(0, 1, 5, 0, 0, 0);
        repeat (3) step(0, 1, 3, 0, 0, 0);
        step(0, 0, 3, 0, 0, 0);
        step(0, 1, 4, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 15)));
        end
        step(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
